ssd_char_buffer: RTL and testbench
==================================

// Module: ssd_char_buffer
// PURPOSE
//  Upstream feeder of the 4-digit SSD control unit. Accepts decoded Morse characters over a
//  valid/ready handshake and keeps the last four in a left-scrolling buffer (newest rightmost).
//  Encodes each slot to an active-low 8-bit cathode pattern and drives the packed 32-bit word
//  that the SSD multiplexer consumes.
// PARAMETERS
//  CODE_W     6           character code width (0-25 = A-Z, 26-35 = '0'-'9', 36 = blank, 63 = error)
//  BLINK_DIV  25_000_000  clk cycles per cursor half-period (used only with SSD_CURSOR_BLINK_EN)
// PORTS
//  clk                      in   1       system clock, single clock domain
//  rst                      in   1       reset, asynchronous, active-low
//  char_valid               in   1       char_code valid
//  char_code                in   CODE_W  decoded character
//  char_ready               out  1       block can accept a character this cycle
//  clear                    in   1       blank all four slots
//  bksp                     in   1       delete newest character
//  cathode_config_combined  out  32      [31:24] digit 0 (leftmost) .. [7:0] digit 3, active low
//  char_count               out  3       occupied slots, 0..4
// BEHAVIOUR
//  Reset (rst=0, async):
//   - All slots = blank code; cathode_config_combined = 32'hFFFF_FFFF.
//   - char_count = 0; FSM = IDLE; char_ready = 1 once rst is released.
//  Segment map, per byte {dp,g,f,e,d,c,b,a}, 0 = lit:
//   - A=8'h88, 1=8'hF9, 0=8'hC0, '-'=8'hBF, blank=8'hFF.
//   - Error code 63 and any undefined code display '-'.
//  FSM IDLE -> SHIFT -> ENCODE -> IDLE:
//   - IDLE: char_ready = (state==IDLE) & ~clear & ~bksp.
//   - Accept = char_valid & char_ready -> capture char_code, go to SHIFT.
//   - SHIFT (1 cycle): slot0<=slot1, slot1<=slot2, slot2<=slot3, slot3<=captured code.
//     char_count <= min(char_count+1, 4). Slot0 is discarded when full (wrap-around scroll, no stall).
//   - ENCODE (1 cycle): register all four encoded bytes into cathode_config_combined.
//  Latency and throughput:
//   - Output updates on the 2nd rising edge after the accept edge.
//   - char_ready = 0 in SHIFT and ENCODE; max one char per 3 cycles.
//  Clear (IDLE only; otherwise held off until IDLE):
//   - All slots blank, char_count <= 0, output = 32'hFFFF_FFFF via ENCODE.
//   - Sample clear/bksp at IDLE only; pulses shorter than reaching IDLE may be lost;
//     sources hold them until char_ready would be 1.
//  Bksp (IDLE only):
//   - slot3<=slot2, slot2<=slot1, slot1<=slot0, slot0<=blank.
//   - char_count <= max(char_count-1, 0); passes through ENCODE.
//   - Bksp at char_count=0: no slot change, still re-encodes.
//  Simultaneous events: priority clear > bksp > char_valid; the losing char is not accepted.
//  Reset mid-operation: FSM aborts immediately to IDLE; the captured character is discarded.
// CONFIGURATION
//  SSD_CURSOR_BLINK_EN defined:
//   - Free-running counter toggles a cursor bit every BLINK_DIV cycles.
//   - While char_count<4 and state==IDLE, bit 7 (dp) of cathode_config_combined = ~cursor;
//     otherwise dp stays 1.
//   - Counter and cursor reset to 0.
//  SSD_CURSOR_BLINK_EN undefined:
//   - No counter; dp of every digit is constantly 1; BLINK_DIV unused.
// TESTING
//  1 Reset: rst=0 -> cathode_config_combined=32'hFFFFFFFF, char_count=0; release -> char_ready=1.
//  2 Send code 0 ('A') with valid held -> output 32'hFFFFFF88 two edges after accept;
//    char_ready low exactly 2 cycles; char_count=1.
//  3 Send A,1,0,63,A back-to-back -> after last, output 32'hF9C0BF88, char_count=4 (saturated).
//  4 From state of 3, bksp -> 32'hFFF9C0BF, count=3; clear+char_valid same cycle ->
//    32'hFFFFFFFF, count=0, char not taken.
//  5 Assert rst during SHIFT -> output 32'hFFFFFFFF, count=0, no ghost char on the next accept.
//  6 SSD_CURSOR_BLINK_EN with BLINK_DIV=4, idle, count=0 -> bit7 toggles every 4 cycles;
//    fill to 4 -> bit7 stays 1.

Source files
------------

// File: rtl/ssd_char_buffer.sv
// Purpose : keeps the last four Morse characters (newest rightmost) and drives active-low SSD cathodes.
// Latency : output word updates on the 2nd rising edge after an accepted character; clear/bksp on the 1st.
// Backpres: char_ready drops for SHIFT/ENCODE (one char per 3 cycles) and while clear/bksp are pending.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   char_valid/char_code     incoming character (valid/ready with char_ready)
//   clear, bksp              blank all slots / delete newest character (sampled in IDLE only)
//   cathode_config_combined  [31:24] leftmost digit .. [7:0] rightmost digit, {dp,g..a}, 0 = lit
//   char_count               occupied slots, 0..4
// Build option: define SSD_CURSOR_BLINK_EN to blink the rightmost dp as a cursor while not full.
module ssd_char_buffer #(
  parameter int CODE_W    = 6,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              char_valid,
  input  logic [CODE_W-1:0] char_code,
  output logic              char_ready,
  input  logic              clear,
  input  logic              bksp,
  output logic [31:0]       cathode_config_combined,
  output logic [2:0]        char_count
);

  localparam logic [CODE_W-1:0] BLANK = CODE_W'(36);

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  state_t            state, state_nxt;
  logic              accept, do_clear, do_bksp;
  logic [CODE_W-1:0] slot0, slot1, slot2, slot3, cap;
  logic [31:0]       enc_q;
  logic              dp;

  // Active-low {dp,g,f,e,d,c,b,a}. Error code and anything unmapped show '-'.
  function automatic logic [7:0] seg_of(input logic [CODE_W-1:0] c);
    logic [7:0] s;
    case (int'(c))
      0:  s = 8'h88;  1:  s = 8'h83;  2:  s = 8'hC6;  3:  s = 8'hA1;
      4:  s = 8'h86;  5:  s = 8'h8E;  6:  s = 8'hC2;  7:  s = 8'h89;
      8:  s = 8'hCF;  9:  s = 8'hE1;  10: s = 8'h8A;  11: s = 8'hC7;
      12: s = 8'hC8;  13: s = 8'hAB;  14: s = 8'hA3;  15: s = 8'h8C;
      16: s = 8'h98;  17: s = 8'hAF;  18: s = 8'h92;  19: s = 8'h87;
      20: s = 8'hC1;  21: s = 8'hE3;  22: s = 8'h81;  23: s = 8'h89;
      24: s = 8'h91;  25: s = 8'hA4;
      26: s = 8'hC0;  27: s = 8'hF9;  28: s = 8'hA4;  29: s = 8'hB0;
      30: s = 8'h99;  31: s = 8'h92;  32: s = 8'h82;  33: s = 8'hF8;
      34: s = 8'h80;  35: s = 8'h90;
      36: s = 8'hFF;
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // clear beats bksp beats a character; a losing character sees char_ready=0.
  always_comb begin
    state_nxt  = state;
    char_ready = 1'b0;
    accept     = 1'b0;
    do_clear   = 1'b0;
    do_bksp    = 1'b0;
    case (state)
      IDLE: begin
        char_ready = ~clear & ~bksp;
        if (clear) begin
          do_clear  = 1'b1;
          state_nxt = ENCODE;
        end else if (bksp) begin
          do_bksp   = 1'b1;
          state_nxt = ENCODE;
        end else if (char_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT:   state_nxt = ENCODE;
      ENCODE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot0      <= BLANK;
      slot1      <= BLANK;
      slot2      <= BLANK;
      slot3      <= BLANK;
      cap        <= BLANK;
      char_count <= 3'd0;
      enc_q      <= 32'hFFFF_FFFF;
    end else begin
      if (accept) cap <= char_code;

      if (do_clear) begin
        slot0      <= BLANK;
        slot1      <= BLANK;
        slot2      <= BLANK;
        slot3      <= BLANK;
        char_count <= 3'd0;
      end else if (do_bksp && char_count != 3'd0) begin
        slot3      <= slot2;
        slot2      <= slot1;
        slot1      <= slot0;
        slot0      <= BLANK;
        char_count <= char_count - 3'd1;
      end

      // Scroll left; when full the leftmost character simply falls off.
      if (state == SHIFT) begin
        slot0 <= slot1;
        slot1 <= slot2;
        slot2 <= slot3;
        slot3 <= cap;
        if (char_count != 3'd4) char_count <= char_count + 3'd1;
      end

      if (state == ENCODE) enc_q <= {seg_of(slot0), seg_of(slot1), seg_of(slot2), seg_of(slot3)};
    end
  end

`ifdef SSD_CURSOR_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0] blink_cnt;
  logic             cursor;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      cursor    <= 1'b0;
    end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      cursor    <= ~cursor;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Cursor only shows while there is room and no update is in flight.
  assign dp = (char_count < 3'd4 && state == IDLE) ? ~cursor : 1'b1;
`else
  // No cursor: the rightmost dp stays dark; the blink period has no effect.
  assign dp = 1'b1 | (BLINK_DIV == 0);
`endif

  // Encoded bytes always carry dp=1, so AND-ing lets the cursor pull it low.
  assign cathode_config_combined = {enc_q[31:8], dp & enc_q[7], enc_q[6:0]};

endmodule

// File: tb/tb_ssd_char_buffer.sv
// Purpose : directed self-checking bench for ssd_char_buffer.
// Latency : checks outputs #1 after the rising edge they depend on.
// Backpres: waits on char_ready with a bounded cycle budget.
module tb_ssd_char_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        char_valid = 1'b0;
  logic [5:0]  char_code = '0;
  logic        char_ready;
  logic        clear = 1'b0;
  logic        bksp = 1'b0;
  logic [31:0] cathode_config_combined;
  logic [2:0]  char_count;

  int checks = 0;
  int errors = 0;

`ifdef SSD_CURSOR_BLINK_EN
  localparam logic [31:0] DP_MASK = 32'hFFFF_FF7F;
`else
  localparam logic [31:0] DP_MASK = 32'hFFFF_FFFF;
`endif

  ssd_char_buffer #(.CODE_W(6), .BLINK_DIV(4)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .char_valid              (char_valid),
    .char_code               (char_code),
    .char_ready              (char_ready),
    .clear                   (clear),
    .bksp                    (bksp),
    .cathode_config_combined (cathode_config_combined),
    .char_count              (char_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] exp);
    check(tag, cathode_config_combined & DP_MASK, exp & DP_MASK);
  endtask

  // Returns just after the accept edge (DUT is then in SHIFT).
  task automatic send(input logic [5:0] code);
    int n = 0;
    char_valid = 1'b1;
    char_code  = code;
    while (!char_ready && n < 10) begin
      tick();
      n++;
    end
    if (!char_ready) check("send_ready_timeout", 32'(char_ready), 32'd1);
    tick();
    char_valid = 1'b0;
  endtask

  initial begin
    // Reset
    tick();
    tick();
    chk_out("rst_out", 32'hFFFF_FFFF);
    check("rst_count", 32'(char_count), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_ready", 32'(char_ready), 32'd1);

    // Single 'A' with valid held through the busy cycles
    char_valid = 1'b1;
    char_code  = 6'd0;
    tick();
    check("a_ready_shift", 32'(char_ready), 32'd0);
    chk_out("a_out_shift", 32'hFFFF_FFFF);
    tick();
    check("a_ready_encode", 32'(char_ready), 32'd0);
    chk_out("a_out_encode", 32'hFFFF_FFFF);
    check("a_count", 32'(char_count), 32'd1);
    char_valid = 1'b0;
    tick();
    check("a_ready_idle", 32'(char_ready), 32'd1);
    chk_out("a_out", 32'hFFFF_FF88);

    // Back-to-back fill past capacity: A,1,0,err,A
    send(6'd0);
    send(6'd27);
    send(6'd26);
    send(6'd63);
    send(6'd0);
    tick();
    tick();
    chk_out("fill_out", 32'hF9C0_BF88);
    check("fill_count", 32'(char_count), 32'd4);

    // Backspace
    bksp = 1'b1;
    #1;
    check("bksp_ready", 32'(char_ready), 32'd0);
    tick();
    bksp = 1'b0;
    check("bksp_count", 32'(char_count), 32'd3);
    tick();
    chk_out("bksp_out", 32'hFFF9_C0BF);

    // Clear wins over a simultaneous character
    clear      = 1'b1;
    char_valid = 1'b1;
    char_code  = 6'd27;
    #1;
    check("clr_ready", 32'(char_ready), 32'd0);
    tick();
    clear      = 1'b0;
    char_valid = 1'b0;
    tick();
    chk_out("clr_out", 32'hFFFF_FFFF);
    check("clr_count", 32'(char_count), 32'd0);
    tick();
    tick();
    tick();
    chk_out("clr_no_char_out", 32'hFFFF_FFFF);
    check("clr_no_char_count", 32'(char_count), 32'd0);

    // Backspace on an empty buffer
    bksp = 1'b1;
    tick();
    bksp = 1'b0;
    tick();
    chk_out("bksp0_out", 32'hFFFF_FFFF);
    check("bksp0_count", 32'(char_count), 32'd0);

    // Reset while in SHIFT drops the in-flight character
    send(6'd27);
    tick();
    tick();
    chk_out("pre_rst_out", 32'hFFFF_FFF9);
    send(6'd0);
    rst = 1'b0;
    #1;
    chk_out("midrst_out", 32'hFFFF_FFFF);
    check("midrst_count", 32'(char_count), 32'd0);
    tick();
    rst = 1'b1;
    send(6'd26);
    tick();
    tick();
    chk_out("post_rst_out", 32'hFFFF_FFC0);
    check("post_rst_count", 32'(char_count), 32'd1);

`ifdef SSD_CURSOR_BLINK_EN
    begin
      logic cur;
      int   n = 0;
      cur = cathode_config_combined[7];
      while (cathode_config_combined[7] == cur && n < 10) begin
        tick();
        n++;
      end
      check("blink_edge_seen", 32'(cathode_config_combined[7] != cur), 32'd1);
      cur = cathode_config_combined[7];
      for (int k = 1; k <= 4; k++) begin
        tick();
        if (k < 4) check("blink_hold", 32'(cathode_config_combined[7]), 32'(cur));
        else       check("blink_toggle", 32'(cathode_config_combined[7]), 32'(~cur));
      end
      send(6'd0);
      send(6'd0);
      send(6'd0);
      tick();
      tick();
      for (int k = 0; k < 10; k++) begin
        check("blink_full_dp", 32'(cathode_config_combined[7]), 32'd1);
        tick();
      end
    end
`else
    for (int k = 0; k < 6; k++) begin
      check("dp_dark", 32'(cathode_config_combined[7]), 32'd1);
      tick();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
